// File: rtl/ball_renderer.sv
// ball_renderer: turns each accepted (x, y) ball position into a stream of
// single-pixel plot requests. The previous square is erased in BG_COLOUR,
// then the new square is drawn in BALL_COLOUR, then done pulses for one cycle.
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   req       new position valid
//   x, y      ball top-left corner, captured when req && ready
//   ready     idle, able to accept a position (decoded from state)
//   done      one-cycle pulse after the last pixel of the new square
//   plot      write pixel (px, py) in colour this cycle
//   px, py    pixel coordinates (low 9/8 bits of the scan address)
//   colour    pixel colour
//   state_dbg current FSM state (IDLE=0, ERASE=1, DRAW=2, DONE=3)
//
// Handshake: a position transfers on a rising edge where req=1 and ready=1.
// There is no queue; req seen while ready=0 is dropped, so the producer holds
// req (or re-issues it) until it observes ready.
module ball_renderer #(
  parameter int         BALL_SIZE   = 4,
  parameter int         X_MAX       = 320,
  parameter int         Y_MAX       = 240,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [2:0] BALL_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [8:0] x,
  input  logic [7:0] y,
  output logic       ready,
  output logic       done,
  output logic       plot,
  output logic [8:0] px,
  output logic [7:0] py,
  output logic [2:0] colour,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0] LAST = 3'(BALL_SIZE - 1);

  state_t     state, state_d;
  logic [2:0] cx, cx_d, cy, cy_d;
  logic [8:0] old_x, old_x_d, new_x, new_x_d;
  logic [7:0] old_y, old_y_d, new_y, new_y_d;
  logic       has_prev, has_prev_d;

  logic       plot_d, done_d;
  logic [8:0] px_d;
  logic [7:0] py_d;
  logic [2:0] colour_d;

  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic       scanning;

  // The output registers are loaded from the state and counters being entered,
  // so the pixel for (cx, cy) appears in the same cycle the FSM sits on it.
  always_comb begin
    state_d    = state;
    cx_d       = cx;
    cy_d       = cy;
    old_x_d    = old_x;
    old_y_d    = old_y;
    new_x_d    = new_x;
    new_y_d    = new_y;
    has_prev_d = has_prev;

    case (state)
      IDLE: begin
        if (req) begin
          new_x_d = x;
          new_y_d = y;
          cx_d    = 3'd0;
          cy_d    = 3'd0;
          state_d = has_prev ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (cx == LAST && cy == LAST) begin
          cx_d = 3'd0;
          cy_d = 3'd0;
          if (state == ERASE) begin
            state_d = DRAW;
          end else begin
            old_x_d    = new_x;
            old_y_d    = new_y;
            has_prev_d = 1'b1;
            state_d    = DONE;
          end
        end else if (cx == LAST) begin
          cx_d = 3'd0;
          cy_d = cy + 3'd1;
        end else begin
          cx_d = cx + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Widened sums so off-screen corners never wrap back onto the screen.
    scanning = (state_d == ERASE) || (state_d == DRAW);
    base_x   = (state_d == ERASE) ? old_x : new_x_d;
    base_y   = (state_d == ERASE) ? old_y : new_y_d;
    sum_x    = {1'b0, base_x} + {7'b0, cx_d};
    sum_y    = {1'b0, base_y} + {6'b0, cy_d};

    plot_d   = scanning && (sum_x < 10'(X_MAX)) && (sum_y < 9'(Y_MAX));
    px_d     = scanning ? sum_x[8:0] : 9'd0;
    py_d     = scanning ? sum_y[7:0] : 8'd0;
    colour_d = (state_d == ERASE) ? BG_COLOUR :
               (state_d == DRAW)  ? BALL_COLOUR : 3'b000;
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cx       <= 3'd0;
      cy       <= 3'd0;
      old_x    <= 9'd0;
      old_y    <= 8'd0;
      new_x    <= 9'd0;
      new_y    <= 8'd0;
      has_prev <= 1'b0;
      plot     <= 1'b0;
      done     <= 1'b0;
      px       <= 9'd0;
      py       <= 8'd0;
      colour   <= 3'b000;
    end else begin
      state    <= state_d;
      cx       <= cx_d;
      cy       <= cy_d;
      old_x    <= old_x_d;
      old_y    <= old_y_d;
      new_x    <= new_x_d;
      new_y    <= new_y_d;
      has_prev <= has_prev_d;
      plot     <= plot_d;
      done     <= done_d;
      px       <= px_d;
      py       <= py_d;
      colour   <= colour_d;
    end
  end

  assign ready     = (state == IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ball_renderer.sv
// Bench for ball_renderer: directed positions, expected pixels queued when a
// position is driven and popped whenever the renderer plots.
module tb_ball_renderer;
  localparam int BS = 4;
  localparam int N  = BS * BS;
  localparam int XM = 320;
  localparam int YM = 240;
  localparam int W  = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic [8:0] x;
  logic [7:0] y;
  logic       ready, done, plot;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] colour;
  logic [1:0] state_dbg;

  ball_renderer dut (
    .clock(clock), .reset(reset), .req(req), .x(x), .y(y),
    .ready(ready), .done(done), .plot(plot), .px(px), .py(py),
    .colour(colour), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];
  bit m_has_prev = 1'b0;
  int m_old_x = 0;
  int m_old_y = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_square(input int bx, input int by, input logic [2:0] c);
    for (int j = 0; j < BS; j++)
      for (int i = 0; i < BS; i++) begin
        int sx, sy;
        logic [8:0] ex;
        logic [7:0] ey;
        sx = bx + i;
        sy = by + j;
        if (sx < XM && sy < YM) begin
          ex = sx[8:0];
          ey = sy[7:0];
          exp_q.push_back({ex, ey, c});
        end
      end
  endtask

  task automatic scan_cycle();
    logic [W-1:0] e;
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_plot", {px, py, colour}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {px, py, colour}, e);
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clock);
    check("ready_wait", ready, 1);
  endtask

  // Drives one position and follows it to completion; hold keeps req high
  // with changing coordinates throughout the render.
  task automatic run_ball(input int bx, input int by, input bit hold);
    int lat;
    if (m_has_prev) push_square(m_old_x, m_old_y, 3'b000);
    push_square(bx, by, 3'b111);
    lat = m_has_prev ? 2 * N + 1 : N + 1;
    wait_ready();
    req = 1'b1;
    x = 9'(bx);
    y = 8'(by);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clock);
      if (!hold && c == 1) req = 1'b0;
      if (hold) begin
        x = 9'($urandom_range(0, 511));
        y = 8'($urandom_range(0, 255));
      end
      scan_cycle();
      check("done", done, (c == lat) ? 1 : 0);
      check("ready", ready, (c == lat + 1) ? 1 : 0);
    end
    check("leftover", exp_q.size(), 0);
    exp_q.delete();
    m_has_prev = 1'b1;
    m_old_x = bx;
    m_old_y = by;
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    x     = 9'd0;
    y     = 8'd0;
    repeat (3) @(negedge clock);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_px", px, 0);
    check("rst_py", py, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;
    @(negedge clock);

    run_ball(100, 50, 1'b0);
    run_ball(101, 50, 1'b0);
    run_ball(318, 238, 1'b0);
    run_ball(200, 100, 1'b0);
    run_ball(200, 100, 1'b0);
    run_ball(60, 70, 1'b1);
    run_ball(61, 70, 1'b0);
    run_ball(511, 255, 1'b0);
    run_ball(511, 255, 1'b0);

    // Reset in the fifth DRAW cycle of a render that has an erase phase.
    push_square(m_old_x, m_old_y, 3'b000);
    push_square(20, 30, 3'b111);
    wait_ready();
    req = 1'b1;
    x = 9'd20;
    y = 8'd30;
    for (int c = 1; c <= N + 5; c++) begin
      @(negedge clock);
      if (c == 1) req = 1'b0;
      scan_cycle();
    end
    check("pre_rst_pixels_left", exp_q.size(), N - 5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_plot", plot, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    m_has_prev = 1'b0;
    m_old_x = 0;
    m_old_y = 0;
    run_ball(40, 40, 1'b0);

    for (int k = 0; k < 3; k++)
      run_ball($urandom_range(0, 511), $urandom_range(0, 255), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
